// File: rtl/preproc_pkg.sv
// Shared preprocessor types: scheduler state encoding, error counter width
// and a saturating increment helper.
package preproc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      ISSUE   = 2'd2
   } sched_state_t;

   localparam int ERR_CNT_W = 16;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/moving_diff_frame_scheduler_frame_assembler.sv
// Frame assembler: checks channel tags, fills the per-channel frame buffer,
// tracks the expected slot and drops partial frames that stall too long.
module frame_assembler
   import preproc_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clear,
   input  logic                       i_accept_en,
   input  logic                       i_s_valid,
   input  logic signed [DATA_W-1:0]   i_s_data,
   input  logic [$clog2(NUM_CH)-1:0]  i_s_ch,
   output logic [NUM_CH*DATA_W-1:0]   o_frame,
   output logic                       o_frame_done,
   output logic                       o_frame_err
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [CH_W-1:0]  r_idx;
   logic [TMO_W-1:0] r_tmo;

   logic w_accept;
   logic w_match;
   logic w_mismatch;
   logic w_resync;
   logic w_last;
   logic w_timeout;

   assign w_accept     = i_accept_en && i_s_valid;
   assign w_match      = w_accept && (i_s_ch == r_idx);
   assign w_mismatch   = w_accept && (i_s_ch != r_idx);
   assign w_resync     = w_mismatch && (i_s_ch == '0);
   assign w_last       = (r_idx == CH_W'(NUM_CH - 1));
   assign w_timeout    = i_accept_en && !w_accept && (r_idx != '0)
                         && (r_tmo == TMO_W'(TIMEOUT - 1));
   assign o_frame_done = w_match && w_last && !i_clear;
   assign o_frame_err  = !i_clear && (w_mismatch || w_timeout);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx <= '0;
         r_tmo <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_tmo <= '0;
      end else if (w_match) begin
         r_idx <= w_last ? '0 : r_idx + 1'b1;
         r_tmo <= '0;
      end else if (w_mismatch) begin
         // A mismatching tag 0 is taken as the start of the next frame.
         r_idx <= w_resync ? CH_W'(1) : '0;
         r_tmo <= '0;
      end else if (w_timeout) begin
         r_idx <= '0;
         r_tmo <= '0;
      end else if (i_accept_en && (r_idx != '0)) begin
         r_tmo <= r_tmo + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
         logic              w_wr;
         logic [DATA_W-1:0] r_buf;
         logic [DATA_W-1:0] r_frame;

         assign w_wr = (w_match && (r_idx == CH_W'(gi))) || (w_resync && (gi == 0));

         // The completing sample bypasses the buffer straight into the frame.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_buf   <= '0;
               r_frame <= '0;
            end else begin
               if (w_wr)
                  r_buf <= i_s_data;
               if (o_frame_done)
                  r_frame <= w_wr ? i_s_data : r_buf;
            end
         end

         assign o_frame[gi*DATA_W +: DATA_W] = r_frame;
      end
   endgenerate

endmodule

// File: rtl/moving_diff_frame_scheduler.sv
// Frame scheduler for the moving-difference filter bank: gathers one tagged
// frame per sample period and strobes it into every filter at once.
module moving_diff_frame_scheduler
   import preproc_pkg::*;
#(
   parameter int NUM_CH        = 8,
   parameter int WINDOW_LENGTH = 128,
   parameter int DATA_W        = 32,
   parameter int TIMEOUT       = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic                       i_stop,
   input  logic                       i_s_valid,
   input  logic signed [DATA_W-1:0]   i_s_data,
   input  logic [$clog2(NUM_CH)-1:0]  i_s_ch,
   output logic                       o_s_ready,
   output logic                       o_filt_en,
   output logic                       o_filt_valid_in,
   output logic [NUM_CH*DATA_W-1:0]   o_filt_data,
   output logic                       o_warm,
   output logic [ERR_CNT_W-1:0]       o_err_cnt
);

   localparam int WARM_MAX = WINDOW_LENGTH + 2;
   localparam int WARM_W   = $clog2(WARM_MAX + 1);

   sched_state_t      r_state;
   sched_state_t      w_state_next;
   logic              r_s_ready;
   logic              r_filt_en;
   logic              r_filt_valid_in;
   logic              r_warm;
   logic [WARM_W-1:0] r_warm_cnt;
   logic [WARM_W-1:0] w_warm_cnt_next;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic              w_frame_done;
   logic              w_frame_err;

   frame_assembler #(
      .NUM_CH  (NUM_CH),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_frame_assembler (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (i_stop),
      .i_accept_en  (r_s_ready),
      .i_s_valid    (i_s_valid),
      .i_s_data     (i_s_data),
      .i_s_ch       (i_s_ch),
      .o_frame      (o_filt_data),
      .o_frame_done (w_frame_done),
      .o_frame_err  (w_frame_err)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_next = COLLECT;
         COLLECT: if (w_frame_done) w_state_next = ISSUE;
         ISSUE:   w_state_next = COLLECT;
         default: w_state_next = IDLE;
      endcase
      if (i_stop)
         w_state_next = IDLE;
   end

   // Warm-up also covers the two-stage sum/average pipeline inside each filter.
   always_comb begin
      w_warm_cnt_next = r_warm_cnt;
      if (i_stop)
         w_warm_cnt_next = '0;
      else if ((r_state == ISSUE) && (r_warm_cnt != WARM_W'(WARM_MAX)))
         w_warm_cnt_next = r_warm_cnt + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state         <= IDLE;
         r_s_ready       <= 1'b0;
         r_filt_en       <= 1'b0;
         r_filt_valid_in <= 1'b0;
         r_warm_cnt      <= '0;
         r_warm          <= 1'b0;
         r_err_cnt       <= '0;
      end else begin
         r_state         <= w_state_next;
         r_s_ready       <= (w_state_next == COLLECT);
         r_filt_en       <= (w_state_next != IDLE);
         r_filt_valid_in <= (w_state_next == ISSUE);
         r_warm_cnt      <= w_warm_cnt_next;
         r_warm          <= (w_warm_cnt_next == WARM_W'(WARM_MAX));
         if (w_frame_err)
            r_err_cnt <= sat_inc(r_err_cnt);
      end
   end

   assign o_s_ready       = r_s_ready;
   assign o_filt_en       = r_filt_en;
   assign o_filt_valid_in = r_filt_valid_in;
   assign o_warm          = r_warm;
   assign o_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_moving_diff_frame_scheduler.sv
// Directed bench for moving_diff_frame_scheduler with NUM_CH=4,
// WINDOW_LENGTH=4, TIMEOUT=16.
module tb_moving_diff_frame_scheduler;

   localparam int NUM_CH  = 4;
   localparam int WL      = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic                     clk;
   logic                     rst;
   logic                     start;
   logic                     stop;
   logic                     s_valid;
   logic signed [DATA_W-1:0] s_data;
   logic [1:0]               s_ch;
   logic                     s_ready;
   logic                     filt_en;
   logic                     filt_valid_in;
   logic [NUM_CH*DATA_W-1:0] filt_data;
   logic                     warm;
   logic [15:0]              err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   moving_diff_frame_scheduler #(
      .NUM_CH        (NUM_CH),
      .WINDOW_LENGTH (WL),
      .DATA_W        (DATA_W),
      .TIMEOUT       (TIMEOUT)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_start         (start),
      .i_stop          (stop),
      .i_s_valid       (s_valid),
      .i_s_data        (s_data),
      .i_s_ch          (s_ch),
      .o_s_ready       (s_ready),
      .o_filt_en       (filt_en),
      .o_filt_valid_in (filt_valid_in),
      .o_filt_data     (filt_data),
      .o_warm          (warm),
      .o_err_cnt       (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NUM_CH*DATA_W-1:0] frame_of(input int a, input int b,
                                                         input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input int d);
      logic [31:0] chv;
      chv     = 32'(ch);
      s_valid = 1'b1;
      s_ch    = chv[1:0];
      s_data  = d;
      step();
      s_valid = 1'b0;
      $display("send ch=%0d data=%0d err_cnt=%0d valid_in=%0b warm=%0b",
               ch, d, err_cnt, filt_valid_in, warm);
   endtask

   task automatic send_frame(input int base);
      for (int c = 0; c < NUM_CH; c++)
         send(c, base + 10 * (c + 1));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      n_checks++; if (filt_en !== 1'b0) begin n_fail++; $display("FAIL reset_filt_en: got %b want 0", filt_en); end
      n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_valid_in: got %b want 0", filt_valid_in); end
      n_checks++; if (filt_data !== '0) begin n_fail++; $display("FAIL reset_filt_data: got %h want 0", filt_data); end
      n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL reset_warm: got %b want 0", warm); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++; if (filt_en !== 1'b0) begin n_fail++; $display("FAIL idle_filt_en: got %b want 0", filt_en); end
   endtask

   task automatic test_single_frame();
      pulse_start();
      n_checks++; if (filt_en !== 1'b1) begin n_fail++; $display("FAIL start_filt_en: got %b want 1", filt_en); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL start_s_ready: got %b want 1", s_ready); end
      send(0, 10); send(1, 20); send(2, 30);
      n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL partial_valid_in: got %b want 0", filt_valid_in); end
      n_checks++; if (filt_data !== '0) begin n_fail++; $display("FAIL partial_filt_data: got %h want 0", filt_data); end
      send(3, 40);
      n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL issue_valid_in: got %b want 1", filt_valid_in); end
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL issue_s_ready: got %b want 0", s_ready); end
      n_checks++; if (filt_data !== frame_of(10, 20, 30, 40)) begin n_fail++; $display("FAIL issue_filt_data: got %h want %h", filt_data, frame_of(10, 20, 30, 40)); end
      step();
      n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL post_issue_valid_in: got %b want 0", filt_valid_in); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_issue_s_ready: got %b want 1", s_ready); end
      n_checks++; if (filt_data !== frame_of(10, 20, 30, 40)) begin n_fail++; $display("FAIL hold_filt_data: got %h want %h", filt_data, frame_of(10, 20, 30, 40)); end
   endtask

   task automatic test_warmup();
      int b;
      stop = 1'b1;
      step();
      stop = 1'b0;
      pulse_start();
      n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL warm_restart: got %b want 0", warm); end
      for (int f = 0; f < 7; f++) begin
         b = 100 * (f + 1);
         send_frame(b);
         n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL warm_valid_in_f%0d: got %b want 1", f, filt_valid_in); end
         n_checks++; if (filt_data !== frame_of(b + 10, b + 20, b + 30, b + 40)) begin n_fail++; $display("FAIL warm_data_f%0d: got %h want %h", f, filt_data, frame_of(b + 10, b + 20, b + 30, b + 40)); end
         n_checks++; if (warm !== (f >= 6)) begin n_fail++; $display("FAIL warm_issue_f%0d: got %b want %b", f, warm, (f >= 6)); end
         step();
         n_checks++; if (warm !== (f >= 5)) begin n_fail++; $display("FAIL warm_after_f%0d: got %b want %b", f, warm, (f >= 5)); end
      end
   endtask

   task automatic test_tag_errors();
      send(0, 1); send(1, 2); send(3, 3);
      n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL tag_err_first: got %0d want 1", err_cnt); end
      n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL tag_err_valid_in: got %b want 0", filt_valid_in); end
      send(0, 4); send(2, 5);
      n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL tag_err_second: got %0d want 2", err_cnt); end
      send(0, 6); send(1, 7);
      n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL tag_clean_start: got %0d want 2", err_cnt); end
      send(0, 8);
      n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL tag_resync_err: got %0d want 3", err_cnt); end
      send(1, 9); send(2, 10); send(3, 11);
      n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL resync_valid_in: got %b want 1", filt_valid_in); end
      n_checks++; if (filt_data !== frame_of(8, 9, 10, 11)) begin n_fail++; $display("FAIL resync_data: got %h want %h", filt_data, frame_of(8, 9, 10, 11)); end
      n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL resync_err_hold: got %0d want 3", err_cnt); end
      step();
   endtask

   task automatic test_timeout();
      send(0, 50);
      repeat (TIMEOUT - 1) step();
      n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL tmo_early: got %0d want 3", err_cnt); end
      step();
      n_checks++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL tmo_fire: got %0d want 4", err_cnt); end
      send(0, 60); send(1, 61); send(2, 62); send(3, 63);
      n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL tmo_next_valid_in: got %b want 1", filt_valid_in); end
      n_checks++; if (filt_data !== frame_of(60, 61, 62, 63)) begin n_fail++; $display("FAIL tmo_next_data: got %h want %h", filt_data, frame_of(60, 61, 62, 63)); end
      n_checks++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL tmo_next_err: got %0d want 4", err_cnt); end
      step();
      repeat (TIMEOUT + 4) step();
      n_checks++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL tmo_idx0_idle: got %0d want 4", err_cnt); end
   endtask

   task automatic test_stop_start();
      n_checks++; if (warm !== 1'b1) begin n_fail++; $display("FAIL warm_before_stop: got %b want 1", warm); end
      send(0, 1); send(1, 2);
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      n_checks++; if (filt_en !== 1'b0) begin n_fail++; $display("FAIL stopstart_filt_en: got %b want 0", filt_en); end
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL stopstart_s_ready: got %b want 0", s_ready); end
      n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL stopstart_warm: got %b want 0", warm); end
      step();
      n_checks++; if (filt_en !== 1'b0) begin n_fail++; $display("FAIL idle_hold_filt_en: got %b want 0", filt_en); end
      pulse_start();
      n_checks++; if (filt_en !== 1'b1) begin n_fail++; $display("FAIL restart_filt_en: got %b want 1", filt_en); end
      send(0, 70); send(1, 71); send(2, 72); send(3, 73);
      n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL restart_valid_in: got %b want 1", filt_valid_in); end
      n_checks++; if (filt_data !== frame_of(70, 71, 72, 73)) begin n_fail++; $display("FAIL restart_data: got %h want %h", filt_data, frame_of(70, 71, 72, 73)); end
      n_checks++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL restart_err_kept: got %0d want 4", err_cnt); end
      step();
      n_checks++; if (warm !== 1'b0) begin n_fail++; $display("FAIL restart_warm: got %b want 0", warm); end
   endtask

   task automatic test_stop_in_issue();
      send(0, 80); send(1, 81); send(2, 82); send(3, 83);
      n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL stop_issue_valid_in: got %b want 1", filt_valid_in); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_checks++; if (filt_en !== 1'b0) begin n_fail++; $display("FAIL stop_issue_filt_en: got %b want 0", filt_en); end
      n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL stop_issue_after_valid: got %b want 0", filt_valid_in); end
      n_checks++; if (filt_data !== frame_of(80, 81, 82, 83)) begin n_fail++; $display("FAIL stop_issue_data: got %h want %h", filt_data, frame_of(80, 81, 82, 83)); end
      pulse_start();
   endtask

   task automatic test_reset_async();
      send(0, 1); send(1, 2);
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL arst_s_ready: got %b want 0", s_ready); end
      n_checks++; if (filt_en !== 1'b0) begin n_fail++; $display("FAIL arst_filt_en: got %b want 0", filt_en); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_err_cnt: got %0d want 0", err_cnt); end
      n_checks++; if (filt_data !== '0) begin n_fail++; $display("FAIL arst_filt_data: got %h want 0", filt_data); end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      send(0, 90); send(1, 91); send(2, 92); send(3, 93);
      n_checks++; if (filt_valid_in !== 1'b1) begin n_fail++; $display("FAIL arst_next_valid_in: got %b want 1", filt_valid_in); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_next_err: got %0d want 0", err_cnt); end
      n_checks++; if (filt_data !== frame_of(90, 91, 92, 93)) begin n_fail++; $display("FAIL arst_next_data: got %h want %h", filt_data, frame_of(90, 91, 92, 93)); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL arst_issue_valid_in: got %b want 0", filt_valid_in); end
      n_checks++; if (filt_data !== '0) begin n_fail++; $display("FAIL arst_issue_data: got %h want 0", filt_data); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (filt_valid_in !== 1'b0) begin n_fail++; $display("FAIL arst_hold_valid_in_%0d: got %b want 0", i, filt_valid_in); end
      end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_ch    = '0;
      test_reset();
      test_single_frame();
      test_warmup();
      test_tag_errors();
      test_timeout();
      test_stop_start();
      test_stop_in_issue();
      test_reset_async();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
